// File: rtl/hybrid_branch_predictor_pkg.sv
// ============================================================================
// Module   : bp_pkg
// Brief    : Shared constants, counter helpers and FSM encoding for the
//            hybrid branch predictor (bimodal + gshare + chooser + BTB).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

  // Weakly-not-taken start value for the bimodal and gshare counters
  localparam logic [1:0] CTR_WNT   = 2'b01;
  // Weakly-prefer-gshare start value for the chooser counters
  localparam logic [1:0] CHOOSE_WG = 2'b10;

  // Table walk after reset, then normal operation
  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // Two-bit saturating increment: 11 stays 11
  function automatic logic [1:0] sat_inc(input logic [1:0] i_ctr);
    return (i_ctr == 2'b11) ? i_ctr : i_ctr + 2'b01;
  endfunction

  // Two-bit saturating decrement: 00 stays 00
  function automatic logic [1:0] sat_dec(input logic [1:0] i_ctr);
    return (i_ctr == 2'b00) ? i_ctr : i_ctr - 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hybrid_branch_predictor_if.sv
// ============================================================================
// Module   : hybrid_branch_predictor_if
// Brief    : Fetch-side lookup and EX-side resolution signals of the hybrid
//            branch predictor. master = pipeline side, slave = predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hybrid_branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int GHR_W = 6
);

  logic             ready_o;
  logic             pred_val_i;
  logic [XLEN-1:0]  pred_pc_i;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_target_o;
  logic             pred_hit_o;
  logic [GHR_W-1:0] pred_ghr_o;
  logic             upd_val_i;
  logic [XLEN-1:0]  upd_pc_i;
  logic             upd_taken_i;
  logic [XLEN-1:0]  upd_target_i;
  logic [GHR_W-1:0] upd_ghr_i;
  logic             upd_mispredict_i;

  modport master (
    input  ready_o, pred_taken_o, pred_target_o, pred_hit_o, pred_ghr_o,
    output pred_val_i, pred_pc_i, upd_val_i, upd_pc_i, upd_taken_i,
           upd_target_i, upd_ghr_i, upd_mispredict_i
  );

  modport slave (
    output ready_o, pred_taken_o, pred_target_o, pred_hit_o, pred_ghr_o,
    input  pred_val_i, pred_pc_i, upd_val_i, upd_pc_i, upd_taken_i,
           upd_target_i, upd_ghr_i, upd_mispredict_i
  );

endinterface

`default_nettype wire

// File: rtl/hybrid_branch_predictor_sat_table.sv
// ============================================================================
// Module   : bp_sat_counter_table
// Brief    : 2^IDX_W x 2-bit saturating counter array. One combinational
//            lookup port, one registered write port that either loads
//            INIT_VAL or steps the addressed counter up/down. The current
//            value of the written entry is also exported so the caller can
//            base decisions on pre-update state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_VAL = CTR_WNT
) (
  input  wire logic             clk,
  input  wire logic [IDX_W-1:0] i_rd_idx,
  output logic      [1:0]       o_rd_val,
  input  wire logic             i_wr_en,
  input  wire logic             i_wr_init,
  input  wire logic             i_wr_up,
  input  wire logic [IDX_W-1:0] i_wr_idx,
  output logic      [1:0]       o_wr_old
);

  localparam int c_DEPTH = 1 << IDX_W;

  logic [1:0] r_mem [c_DEPTH];
  logic [1:0] w_wr_val;

  // Reads see the registered array, so a same-cycle write is not visible yet
  assign o_rd_val = r_mem[i_rd_idx];
  assign o_wr_old = r_mem[i_wr_idx];

  // Select between the init constant and a saturating step of the old value
  always_comb begin
    w_wr_val = INIT_VAL;
    if (!i_wr_init) begin
      w_wr_val = i_wr_up ? sat_inc(o_wr_old) : sat_dec(o_wr_old);
    end
  end

  // Storage has no reset; the predictor's INIT walk loads every entry
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= w_wr_val;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hybrid_branch_predictor.sv
// ============================================================================
// Module   : hybrid_branch_predictor
// Brief    : Tournament direction predictor (bimodal + gshare + per-index
//            chooser) with a direct-mapped tagged BTB and a speculative
//            global history register that is repaired on mispredict.
//            Lookup is combinational; resolution updates are registered.
//            Optional statistics counters: define HYBRID_BP_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hybrid_branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int GHR_W     = 6,
  parameter int BTB_IDX_W = 4,
  parameter int TAG_W     = 8
) (
  input wire logic clk,
  input wire logic rst,
  hybrid_branch_predictor_if.slave bp
`ifdef HYBRID_BP_STATS_EN
  ,
  output logic [31:0] stat_lookups_o,
  output logic [31:0] stat_updates_o,
  output logic [31:0] stat_mispred_o
`endif
);

  localparam int c_BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int c_TAG_LO    = BTB_IDX_W + 2;
  localparam int c_TAG_HI    = TAG_W + BTB_IDX_W + 1;

  bp_state_e                r_state;
  bp_state_e                w_state_nxt;
  logic [BHT_IDX_W-1:0]     r_init_idx;
  logic [BHT_IDX_W-1:0]     w_init_idx_nxt;
  logic [GHR_W-1:0]         r_ghr;
  logic                     w_ready;
  logic                     w_init_wr;
  logic                     w_init_btb;

  // Lookup side
  logic [BHT_IDX_W-1:0]     w_bidx;
  logic [BHT_IDX_W-1:0]     w_gidx;
  logic [BTB_IDX_W-1:0]     w_btb_idx;
  logic [TAG_W-1:0]         w_tag;
  logic [1:0]               w_bim_rd;
  logic [1:0]               w_gsh_rd;
  logic [1:0]               w_cho_rd;
  logic                     w_dir;
  logic                     w_hit;
  logic                     w_taken;

  // Update side
  logic                     w_upd_en;
  logic [BHT_IDX_W-1:0]     w_upd_bidx;
  logic [BHT_IDX_W-1:0]     w_upd_gidx;
  logic [BTB_IDX_W-1:0]     w_upd_btb_idx;
  logic [TAG_W-1:0]         w_upd_tag;
  logic [1:0]               w_bim_old;
  logic [1:0]               w_gsh_old;
  logic [1:0]               w_unused_cho_old;
  logic                     w_disagree;
  logic                     w_unused_upd_pc;

  // Table write-port steering
  logic [BHT_IDX_W-1:0]     w_bim_wr_idx;
  logic [BHT_IDX_W-1:0]     w_gsh_wr_idx;
  logic                     w_dir_wr_en;
  logic                     w_cho_wr_en;
  logic                     w_cho_up;

  // BTB storage
  logic [c_BTB_DEPTH-1:0]   r_btb_valid;
  logic [TAG_W-1:0]         r_btb_tag [c_BTB_DEPTH];
  logic [XLEN-1:0]          r_btb_tgt [c_BTB_DEPTH];

  assign w_ready    = (r_state == BP_RUN);
  assign w_init_wr  = (r_state == BP_INIT);
  assign w_init_btb = (int'(r_init_idx) < c_BTB_DEPTH);

  // ---------------------------------------------------------------- FSM
  // State and init-walk index registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BP_INIT;
      r_init_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_idx <= w_init_idx_nxt;
    end
  end

  // Walk every table index once, then settle in RUN
  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    case (r_state)
      BP_INIT: begin
        w_init_idx_nxt = r_init_idx + 1'b1;
        if (&r_init_idx) begin
          w_state_nxt = BP_RUN;
        end
      end
      BP_RUN:  w_state_nxt = BP_RUN;
      default: w_state_nxt = BP_INIT;
    endcase
  end

  // ---------------------------------------------------------------- lookup
  assign w_bidx    = bp.pred_pc_i[BHT_IDX_W+1:2];
  assign w_gidx    = w_bidx ^ BHT_IDX_W'(r_ghr);
  assign w_btb_idx = bp.pred_pc_i[BTB_IDX_W+1:2];
  assign w_tag     = bp.pred_pc_i[c_TAG_HI:c_TAG_LO];

  // Chooser MSB set means trust gshare for this PC
  assign w_dir   = w_cho_rd[1] ? w_gsh_rd[1] : w_bim_rd[1];
  assign w_hit   = w_ready && r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_tag);
  assign w_taken = w_hit && w_dir;

  assign bp.ready_o       = w_ready;
  assign bp.pred_hit_o    = w_hit;
  assign bp.pred_taken_o  = w_taken;
  assign bp.pred_target_o = w_taken ? r_btb_tgt[w_btb_idx] : bp.pred_pc_i + XLEN'(4);
  assign bp.pred_ghr_o    = r_ghr;

  // ---------------------------------------------------------------- update
  assign w_upd_en      = w_ready && bp.upd_val_i;
  assign w_upd_bidx    = bp.upd_pc_i[BHT_IDX_W+1:2];
  assign w_upd_gidx    = w_upd_bidx ^ BHT_IDX_W'(bp.upd_ghr_i);
  assign w_upd_btb_idx = bp.upd_pc_i[BTB_IDX_W+1:2];
  assign w_upd_tag     = bp.upd_pc_i[c_TAG_HI:c_TAG_LO];
  // Only the index/tag bits of the resolved PC matter here
  assign w_unused_upd_pc = ^bp.upd_pc_i;

  // Chooser moves only when the components disagreed before this update
  assign w_disagree = (w_bim_old[1] != w_gsh_old[1]);
  assign w_cho_up   = (w_gsh_old[1] == bp.upd_taken_i);

  assign w_dir_wr_en  = w_init_wr || w_upd_en;
  assign w_cho_wr_en  = w_init_wr || (w_upd_en && w_disagree);
  assign w_bim_wr_idx = w_init_wr ? r_init_idx : w_upd_bidx;
  assign w_gsh_wr_idx = w_init_wr ? r_init_idx : w_upd_gidx;

  bp_sat_counter_table #(.IDX_W(BHT_IDX_W), .INIT_VAL(CTR_WNT)) u_bimodal (
    .clk       (clk),
    .i_rd_idx  (w_bidx),
    .o_rd_val  (w_bim_rd),
    .i_wr_en   (w_dir_wr_en),
    .i_wr_init (w_init_wr),
    .i_wr_up   (bp.upd_taken_i),
    .i_wr_idx  (w_bim_wr_idx),
    .o_wr_old  (w_bim_old)
  );

  bp_sat_counter_table #(.IDX_W(BHT_IDX_W), .INIT_VAL(CTR_WNT)) u_gshare (
    .clk       (clk),
    .i_rd_idx  (w_gidx),
    .o_rd_val  (w_gsh_rd),
    .i_wr_en   (w_dir_wr_en),
    .i_wr_init (w_init_wr),
    .i_wr_up   (bp.upd_taken_i),
    .i_wr_idx  (w_gsh_wr_idx),
    .o_wr_old  (w_gsh_old)
  );

  bp_sat_counter_table #(.IDX_W(BHT_IDX_W), .INIT_VAL(CHOOSE_WG)) u_chooser (
    .clk       (clk),
    .i_rd_idx  (w_bidx),
    .o_rd_val  (w_cho_rd),
    .i_wr_en   (w_cho_wr_en),
    .i_wr_init (w_init_wr),
    .i_wr_up   (w_cho_up),
    .i_wr_idx  (w_bim_wr_idx),
    .o_wr_old  (w_unused_cho_old)
  );

  // BTB: INIT clears valid bits; only taken branches allocate or refresh
  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      if (w_init_btb) begin
        r_btb_valid[r_init_idx[BTB_IDX_W-1:0]] <= 1'b0;
      end
    end else if (w_upd_en && bp.upd_taken_i) begin
      r_btb_valid[w_upd_btb_idx] <= 1'b1;
      r_btb_tag[w_upd_btb_idx]   <= w_upd_tag;
      r_btb_tgt[w_upd_btb_idx]   <= bp.upd_target_i;
    end
  end

  // ---------------------------------------------------------------- GHR
  // Repair from the resolved branch wins over speculative shift-in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= '0;
    end else if (w_ready) begin
      if (bp.upd_val_i && bp.upd_mispredict_i) begin
        r_ghr <= {bp.upd_ghr_i[GHR_W-2:0], bp.upd_taken_i};
      end else if (bp.pred_val_i && w_hit) begin
        r_ghr <= {r_ghr[GHR_W-2:0], w_dir};
      end
    end
  end

`ifdef HYBRID_BP_STATS_EN
  // ---------------------------------------------------------------- stats
  // Saturating event counters, only counted once tables are live
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups_o <= '0;
      stat_updates_o <= '0;
      stat_mispred_o <= '0;
    end else if (w_ready) begin
      if (bp.pred_val_i && (stat_lookups_o != 32'hFFFF_FFFF)) begin
        stat_lookups_o <= stat_lookups_o + 32'd1;
      end
      if (bp.upd_val_i && (stat_updates_o != 32'hFFFF_FFFF)) begin
        stat_updates_o <= stat_updates_o + 32'd1;
      end
      if (bp.upd_val_i && bp.upd_mispredict_i && (stat_mispred_o != 32'hFFFF_FFFF)) begin
        stat_mispred_o <= stat_mispred_o + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
